// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - in-order AXI read responder returning address-pattern data bursts
// Optional macro AXI_RESP_LATENCY_EN inserts latencyCnt idle cycles before each burst.
module axi_read_responder #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_QUEUE_SIZE       = 3,
  parameter int LATENCY_WIDTH        = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 s_ar_valid,
  output logic                                 s_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]           s_ar_len,
  input  logic [ADDR_BITS-1:0]                 s_ar_addr,
  input  logic [TID_WIDTH-1:0]                 s_ar_id,
  output logic                                 s_r_valid,
  input  logic                                 s_r_ready,
  output logic                                 s_r_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] s_r_data,
  output logic [TID_WIDTH-1:0]                 s_r_id,
  input  logic [LATENCY_WIDTH-1:0]             latencyCnt,
  output logic [LOG_QUEUE_SIZE:0]              reqCnt
);

  localparam int DW    = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
  localparam int NREP  = DW / ADDR_BITS;
  localparam logic [LOG_QUEUE_SIZE:0] FULL_CNT = {1'b1, {LOG_QUEUE_SIZE{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t state, state_nx, start_state;

  logic [BURST_LEN_WIDTH-1:0] q_len  [DEPTH];
  logic [ADDR_BITS-1:0]       q_addr [DEPTH];
  logic [TID_WIDTH-1:0]       q_id   [DEPTH];

  logic [LOG_QUEUE_SIZE-1:0]  wr_ptr, rd_ptr;
  logic [LOG_QUEUE_SIZE:0]    req_cnt, cnt_nx;
  logic                       ar_ready;
  logic [BURST_LEN_WIDTH-1:0] act_len, beat_idx;
  logic [ADDR_BITS-1:0]       act_addr, beat_addr;
  logic [TID_WIDTH-1:0]       act_id;
  logic                       push, pop, r_hs, is_last, not_empty;

  assign push      = s_ar_valid && ar_ready;
  assign not_empty = (req_cnt != '0);
  assign is_last   = (beat_idx == act_len);
  assign r_hs      = (state == BURST) && s_r_ready;

`ifdef AXI_RESP_LATENCY_EN
  logic [LATENCY_WIDTH-1:0] lat_cnt;
  assign start_state = (latencyCnt != '0) ? WAIT : BURST;
`else
  logic unused_latency;
  assign unused_latency = ^latencyCnt;
  assign start_state    = BURST;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Finishing a burst with work queued reloads in the same edge, so bursts run back-to-back.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop      = 1'b1;
          state_nx = start_state;
        end
      end
      WAIT: begin
`ifdef AXI_RESP_LATENCY_EN
        if (lat_cnt == LATENCY_WIDTH'(1)) state_nx = BURST;
`else
        state_nx = BURST;
`endif
      end
      BURST: begin
        if (r_hs && is_last) begin
          if (not_empty) begin
            pop      = 1'b1;
            state_nx = start_state;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx = req_cnt;
    case ({push, pop})
      2'b10:   cnt_nx = req_cnt + (LOG_QUEUE_SIZE+1)'(1);
      2'b01:   cnt_nx = req_cnt - (LOG_QUEUE_SIZE+1)'(1);
      default: cnt_nx = req_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_len[wr_ptr]  <= s_ar_len;
      q_addr[wr_ptr] <= s_ar_addr;
      q_id[wr_ptr]   <= s_ar_id;
    end
  end

  // Ready is registered from the next occupancy so it is low throughout reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      req_cnt  <= '0;
      ar_ready <= 1'b0;
      act_len  <= '0;
      act_addr <= '0;
      act_id   <= '0;
      beat_idx <= '0;
`ifdef AXI_RESP_LATENCY_EN
      lat_cnt  <= '0;
`endif
    end else begin
      req_cnt  <= cnt_nx;
      ar_ready <= (cnt_nx != FULL_CNT);
      if (push) wr_ptr <= wr_ptr + LOG_QUEUE_SIZE'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + LOG_QUEUE_SIZE'(1);
        act_len  <= q_len[rd_ptr];
        act_addr <= q_addr[rd_ptr];
        act_id   <= q_id[rd_ptr];
        beat_idx <= '0;
      end else if (r_hs) begin
        beat_idx <= beat_idx + BURST_LEN_WIDTH'(1);
      end
`ifdef AXI_RESP_LATENCY_EN
      if (pop)                lat_cnt <= latencyCnt;
      else if (state == WAIT) lat_cnt <= lat_cnt - LATENCY_WIDTH'(1);
`endif
    end
  end

  assign beat_addr = act_addr + (ADDR_BITS'(beat_idx) << LOG_BLOCK_DATA_BYTES);

  always_comb begin
    s_r_data = '0;
    if (state == BURST) begin
      for (int i = 0; i < NREP; i++) s_r_data[i*ADDR_BITS +: ADDR_BITS] = beat_addr;
    end
  end

  assign s_r_valid  = (state == BURST);
  assign s_r_last   = s_r_valid && is_last;
  assign s_r_id     = s_r_valid ? act_id : '0;
  assign s_ar_ready = ar_ready;
  assign reqCnt     = req_cnt;

endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - scoreboard bench for axi_read_responder with default parameters
module tb_axi_read_responder;

`ifdef AXI_RESP_LATENCY_EN
  localparam int L_EFF = 5;
`else
  localparam int L_EFF = 0;
`endif

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [7:0]   id;
    int           cyc;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_ar_valid = 1'b0;
  logic         s_ar_ready;
  logic [7:0]   s_ar_len = '0;
  logic [63:0]  s_ar_addr = '0;
  logic [7:0]   s_ar_id = '0;
  logic         s_r_valid;
  logic         s_r_ready = 1'b0;
  logic         s_r_last;
  logic [511:0] s_r_data;
  logic [7:0]   s_r_id;
  logic [9:0]   latencyCnt = '0;
  logic [3:0]   reqCnt;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    hs_count = 0;
  bit    chk_gap = 1'b0;
  beat_t exp_q[$];

  axi_read_responder dut (
    .clk(clk), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_len(s_ar_len),
    .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .s_r_data(s_r_data), .s_r_id(s_r_id),
    .latencyCnt(latencyCnt), .reqCnt(reqCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [511:0] rep(input logic [63:0] a);
    return {8{a}};
  endfunction

  task automatic push_beat(input logic [63:0] a, input logic last, input logic [7:0] id, input int c);
    beat_t b;
    b.data = rep(a);
    b.last = last;
    b.id   = id;
    b.cyc  = c;
    exp_q.push_back(b);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drives one AR; returns the cycle in which the handshake happened.
  task automatic send_ar(input logic [7:0] len, input logic [63:0] addr, input logic [7:0] id, output int k);
    int n;
    s_ar_valid = 1'b1;
    s_ar_len   = len;
    s_ar_addr  = addr;
    s_ar_id    = id;
    k = -1;
    n = 0;
    while (k < 0 && n < 200) begin
      @(negedge clk);
      if (s_ar_ready) k = cyc;
      n++;
    end
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL ar_timeout id=%h got=no_handshake want=handshake", id);
    end
    @(posedge clk);
    #1;
    s_ar_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: compares each R handshake against the scoreboard and checks stall stability.
  bit           stall_prev = 1'b0;
  logic [511:0] sv_data;
  logic         sv_last;
  logic [7:0]   sv_id;
  int           gap_prev = -1;
  beat_t        e;

  always @(negedge clk) begin
    if (!chk_gap) gap_prev = -1;
    if (reset) begin
      stall_prev = 1'b0;
    end else if (s_r_valid) begin
      if (stall_prev) begin
        total++;
        if (s_r_data !== sv_data || s_r_last !== sv_last || s_r_id !== sv_id) begin
          bad++;
          $display("FAIL hold data=%h last=%0b id=%h want data=%h last=%0b id=%h",
                   s_r_data[63:0], s_r_last, s_r_id, sv_data[63:0], sv_last, sv_id);
        end
      end
      if (s_r_ready) begin
        hs_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got data=%h id=%h want none", s_r_data[63:0], s_r_id);
        end else begin
          e = exp_q.pop_front();
          if (s_r_data !== e.data || s_r_last !== e.last || s_r_id !== e.id) begin
            bad++;
            $display("FAIL beat data=%h last=%0b id=%h want data=%h last=%0b id=%h",
                     s_r_data, s_r_last, s_r_id, e.data, e.last, e.id);
          end
          if (e.cyc >= 0) begin
            total++;
            if (cyc != e.cyc) begin
              bad++;
              $display("FAIL beat_cycle got=%0d want=%0d", cyc, e.cyc);
            end
          end
        end
        if (chk_gap) begin
          if (gap_prev >= 0) begin
            total++;
            if (cyc != gap_prev + 1) begin
              bad++;
              $display("FAIL drain_gap got=%0d want=%0d", cyc, gap_prev + 1);
            end
          end
          gap_prev = cyc;
        end
      end
      stall_prev = !s_r_ready;
      sv_data    = s_r_data;
      sv_last    = s_r_last;
      sv_id      = s_r_id;
    end else begin
      if (stall_prev) begin
        total++;
        bad++;
        $display("FAIL valid_dropped got=0 want=1");
      end
      stall_prev = 1'b0;
    end
  end

  initial begin
    int k, n, h0, seen;
    logic [63:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("rst_r_valid", 64'(s_r_valid), 64'd0);
    chk("rst_r_last", 64'(s_r_last), 64'd0);
    chk("rst_r_data_or", 64'(|s_r_data), 64'd0);
    chk("rst_r_id", 64'(s_r_id), 64'd0);
    chk("rst_reqcnt", 64'(reqCnt), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ar_ready", 64'(s_ar_ready), 64'd1);

    // Four-beat burst with hand-computed addresses and exact timing.
    s_r_ready = 1'b1;
    send_ar(8'd3, 64'h1000, 8'h05, k);
    push_beat(64'h1000, 1'b0, 8'h05, k + 2);
    push_beat(64'h1040, 1'b0, 8'h05, k + 3);
    push_beat(64'h1080, 1'b0, 8'h05, k + 4);
    push_beat(64'h10C0, 1'b1, 8'h05, k + 5);
    wait_drain("burst4", 100);

    // Latency: single beat lands at k+2+L (latencyCnt ignored without the macro).
    latencyCnt = 10'd5;
    send_ar(8'd0, 64'h3000, 8'h09, k);
    push_beat(64'h3000, 1'b1, 8'h09, k + 2 + L_EFF);
    wait_drain("latency", 100);
    latencyCnt = 10'd0;

    // Address wrap past all-ones.
    send_ar(8'd1, 64'hFFFF_FFFF_FFFF_FFC0, 8'h0A, k);
    push_beat(64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 8'h0A, k + 2);
    push_beat(64'h0, 1'b1, 8'h0A, k + 3);
    wait_drain("wrap", 100);

    // Backpressure pattern 1,0,0,1 on a three-beat burst.
    s_r_ready = 1'b0;
    h0 = hs_count;
    send_ar(8'd2, 64'h4000, 8'h07, k);
    push_beat(64'h4000, 1'b0, 8'h07, -1);
    push_beat(64'h4040, 1'b0, 8'h07, -1);
    push_beat(64'h4080, 1'b1, 8'h07, -1);
    n = 0;
    while (!s_r_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_valid_seen", 64'(s_r_valid), 64'd1);
    s_r_ready = 1'b1; @(posedge clk); #1;
    s_r_ready = 1'b0; @(posedge clk); #1;
    s_r_ready = 1'b0; @(posedge clk); #1;
    s_r_ready = 1'b1;
    wait_drain("stall", 100);
    chk("stall_beats", 64'(hs_count - h0), 64'd3);

    // Fill: nine requests fit (one active + eight queued), then drain gap-free.
    s_r_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = 64'h2000 + 64'(i) * 64'h100;
      send_ar(8'd1, a, 8'(8'h10 + i), k);
      push_beat(a, 1'b0, 8'(8'h10 + i), -1);
      push_beat(a + 64'h40, 1'b1, 8'(8'h10 + i), -1);
      chk($sformatf("fill_reqcnt_%0d", i), 64'(reqCnt), (i == 0) ? 64'd1 : 64'(i));
    end
    s_ar_valid = 1'b1;
    s_ar_id    = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("full_ar_ready", 64'(s_ar_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    s_ar_valid = 1'b0;
    chk("full_reqcnt", 64'(reqCnt), 64'd8);
    chk_gap   = 1'b1;
    s_r_ready = 1'b1;
    wait_drain("drain", 200);
    chk_gap = 1'b0;
    chk("drain_reqcnt", 64'(reqCnt), 64'd0);

    // Reset during beat 2 of a len=7 burst with two more queued.
    s_r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_ar(8'd7, 64'h8000 + 64'(i) * 64'h1000, 8'(8'h30 + i), k);
      for (int b = 0; b < 8; b++)
        push_beat(64'h8000 + 64'(i) * 64'h1000 + 64'(b) * 64'h40, b == 7, 8'(8'h30 + i), -1);
    end
    h0 = hs_count;
    s_r_ready = 1'b1;
    n = 0;
    while (hs_count < h0 + 1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rst_mid_sync", 64'(n < 100), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_r_valid", 64'(s_r_valid), 64'd0);
    chk("mid_rst_r_last", 64'(s_r_last), 64'd0);
    chk("mid_rst_r_data_or", 64'(|s_r_data), 64'd0);
    chk("mid_rst_r_id", 64'(s_r_id), 64'd0);
    chk("mid_rst_reqcnt", 64'(reqCnt), 64'd0);
    chk("mid_rst_ar_ready", 64'(s_ar_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", 64'(s_r_valid), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ar_ready_up", 64'(s_ar_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (s_r_valid) seen++;
    end
    chk("post_rst_no_valid", 64'(seen), 64'd0);

    send_ar(8'd0, 64'h9000, 8'h44, k);
    push_beat(64'h9000, 1'b1, 8'h44, k + 2);
    wait_drain("after_rst", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
